// File: rtl/alu_op_sequencer_pkg.sv
// alu_op_sequencer_pkg: ALU op codes, FSM states and
// sizing helpers shared by the sequencer and the ALU decode.
package alu_op_sequencer_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_SHR = 4'b0100;
    localparam logic [3:0] OP_SHL = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;
    localparam logic [3:0] OP_ROL = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_DIV = 4'b1001;
    localparam logic [3:0] OP_NEG = 4'b1010;
    localparam logic [3:0] OP_NOT = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } seq_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: request, ALU drive and result
// handshake signals between control unit, sequencer and ALU.
interface alu_op_sequencer_if #(
    parameter int REG_SIZE = 32
);
    logic                  start_valid;
    logic                  start_ready;
    logic [3:0]            op;
    logic [REG_SIZE-1:0]   a_in;
    logic [REG_SIZE-1:0]   b_in;
    logic [3:0]            alu_ctrl;
    logic [REG_SIZE-1:0]   alu_a;
    logic [REG_SIZE-1:0]   alu_b;
    logic [2*REG_SIZE-1:0] alu_c;
    logic                  res_valid;
    logic                  res_ready;
    logic [REG_SIZE-1:0]   z_hi;
    logic [REG_SIZE-1:0]   z_lo;
    logic                  div_by_zero;
    logic                  illegal_op;
    logic                  busy;

    modport master (
        output start_valid, op, a_in, b_in, alu_c, res_ready,
        input  start_ready, alu_ctrl, alu_a, alu_b,
        input  res_valid, z_hi, z_lo, div_by_zero, illegal_op, busy
    );

    modport slave (
        input  start_valid, op, a_in, b_in, alu_c, res_ready,
        output start_ready, alu_ctrl, alu_a, alu_b,
        output res_valid, z_hi, z_lo, div_by_zero, illegal_op, busy
    );
endinterface

// File: rtl/alu_op_sequencer_op_latency_lut.sv
// op_latency_lut: maps an ALU op code to its settle
// cycle count and flags illegal codes (combinational).
module op_latency_lut
    import alu_op_sequencer_pkg::*;
#(
    parameter int BASIC_CYC = 1,
    parameter int MUL_CYC   = 4,
    parameter int DIV_CYC   = 8,
    parameter int CW        = 4
) (
    input  logic [3:0]    op,
    output logic [CW-1:0] cyc,
    output logic          illegal,
    output logic          is_div
);

    // Decode op into cycle count and class flags
    always_comb begin
        cyc     = CW'(BASIC_CYC);
        illegal = 1'b0;
        is_div  = 1'b0;
        unique case (1'b1)
            (op == OP_MUL): cyc = CW'(MUL_CYC);
            (op == OP_DIV): begin
                cyc    = CW'(DIV_CYC);
                is_div = 1'b1;
            end
            (op > OP_NOT): illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one op at a time to the shared ALU,
// holds its inputs for the op's settle time, returns the result.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int REG_SIZE  = 32,
    parameter int BASIC_CYC = 1,
    parameter int MUL_CYC   = 4,
    parameter int DIV_CYC   = 8
) (
    input logic              clock,
    input logic              clear,
    alu_op_sequencer_if.slave bus
);

    localparam int CW = $clog2(max3(BASIC_CYC, MUL_CYC, DIV_CYC)) + 1;

    seq_state_t          state;
    logic [CW-1:0]       cnt;
    logic [3:0]          ctrl_q;
    logic [REG_SIZE-1:0] a_q;
    logic [REG_SIZE-1:0] b_q;
    logic [REG_SIZE-1:0] z_hi_q;
    logic [REG_SIZE-1:0] z_lo_q;
    logic                valid_q;
    logic                dz_q;
    logic                il_q;
    logic                dz_pend;
    logic                il_pend;

    logic [CW-1:0]       lut_cyc;
    logic                lut_illegal;
    logic                lut_is_div;
    logic                bypass;
    logic                div_zero;

    op_latency_lut #(
        .BASIC_CYC (BASIC_CYC),
        .MUL_CYC   (MUL_CYC),
        .DIV_CYC   (DIV_CYC),
        .CW        (CW)
    ) u_lut (
        .op      (bus.op),
        .cyc     (lut_cyc),
        .illegal (lut_illegal),
        .is_div  (lut_is_div)
    );

    assign div_zero = lut_is_div && (bus.b_in == '0);
    assign bypass   = lut_illegal || div_zero;

    // FSM, settle counter, operand latch and result capture
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            ctrl_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            z_hi_q  <= '0;
            z_lo_q  <= '0;
            valid_q <= 1'b0;
            dz_q    <= 1'b0;
            il_q    <= 1'b0;
            dz_pend <= 1'b0;
            il_pend <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.start_valid) begin
                        ctrl_q  <= bus.op;
                        a_q     <= bus.a_in;
                        b_q     <= bus.b_in;
                        cnt     <= lut_cyc - CW'(1);
                        dz_pend <= div_zero;
                        il_pend <= lut_illegal;
                        state   <= bypass ? ST_HOLD : ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cnt == '0) begin
                        z_hi_q  <= bus.alu_c[2*REG_SIZE-1:REG_SIZE];
                        z_lo_q  <= bus.alu_c[REG_SIZE-1:0];
                        valid_q <= 1'b1;
                        state   <= ST_HOLD;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_HOLD: begin
                    if (!valid_q) begin
                        // Bypassed op: publish forced-zero result and flag
                        z_hi_q  <= '0;
                        z_lo_q  <= '0;
                        valid_q <= 1'b1;
                        dz_q    <= dz_pend;
                        il_q    <= il_pend;
                    end else if (bus.res_ready) begin
                        valid_q <= 1'b0;
                        dz_q    <= 1'b0;
                        il_q    <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.start_ready = (state == ST_IDLE);
    assign bus.busy        = (state != ST_IDLE);
    assign bus.alu_ctrl    = ctrl_q;
    assign bus.alu_a       = a_q;
    assign bus.alu_b       = b_q;
    assign bus.z_hi        = z_hi_q;
    assign bus.z_lo        = z_lo_q;
    assign bus.res_valid   = valid_q;
    assign bus.div_by_zero = dz_q;
    assign bus.illegal_op  = il_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed checks of latency, capture,
// bypass flags, hold stability, async reset and back-to-back issue.
module tb_alu_op_sequencer;
    import alu_op_sequencer_pkg::*;

    logic clock;
    logic clear;
    int   tests;
    int   fails;
    int   n;

    alu_op_sequencer_if #(.REG_SIZE(32)) bus ();

    alu_op_sequencer #(
        .REG_SIZE  (32),
        .BASIC_CYC (1),
        .MUL_CYC   (4),
        .DIV_CYC   (8)
    ) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stand-in ALU; div by zero and unknown ops return a marker
    always_comb begin
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  s;
        a = bus.alu_a;
        b = bus.alu_b;
        s = b[4:0];
        bus.alu_c = 64'hDEADBEEF_DEADBEEF;
        case (bus.alu_ctrl)
            OP_AND: bus.alu_c = {32'd0, a & b};
            OP_OR:  bus.alu_c = {32'd0, a | b};
            OP_ADD: bus.alu_c = {32'd0, a + b};
            OP_SUB: bus.alu_c = {32'd0, a - b};
            OP_SHR: bus.alu_c = {32'd0, a >> s};
            OP_SHL: bus.alu_c = {32'd0, a << s};
            OP_ROR: bus.alu_c = {32'd0, (a >> s) | (a << (6'd32 - {1'b0, s}))};
            OP_ROL: bus.alu_c = {32'd0, (a << s) | (a >> (6'd32 - {1'b0, s}))};
            OP_MUL: bus.alu_c = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            OP_DIV: if (b != 0) bus.alu_c = {a % b, a / b};
            OP_NEG: bus.alu_c = {32'd0, -a};
            OP_NOT: bus.alu_c = {32'd0, ~a};
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        bus.start_valid = 1'b1;
        bus.op          = o;
        bus.a_in        = a;
        bus.b_in        = b;
        @(posedge clock);
        #1;
        bus.start_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!bus.res_valid && cycles < 40) begin
            @(posedge clock);
            #1;
            cycles++;
        end
    endtask

    task automatic ack();
        bus.res_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.res_ready = 1'b0;
    endtask

    initial begin
        tests           = 0;
        fails           = 0;
        clear           = 1'b0;
        bus.start_valid = 1'b0;
        bus.res_ready   = 1'b0;
        bus.op          = '0;
        bus.a_in        = '0;
        bus.b_in        = '0;

        #12;
        chk("rst_valid", 64'(bus.res_valid), 64'd0);
        chk("rst_ready", 64'(bus.start_ready), 64'd1);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_z", {bus.z_hi, bus.z_lo}, 64'd0);
        chk("rst_ctrl", {28'd0, bus.alu_ctrl, bus.alu_a}, 64'd0);
        @(negedge clock);
        clear = 1'b1;
        @(posedge clock);
        #1;

        // 1: add, single cycle
        bus.res_ready = 1'b1;
        issue(OP_ADD, 32'd5, 32'd7);
        chk("add_busy", 64'(bus.busy), 64'd1);
        wait_valid(n);
        chk("add_lat", 64'(n), 64'd1);
        chk("add_z", {bus.z_hi, bus.z_lo}, 64'd12);
        @(posedge clock);
        #1;
        chk("add_ack_valid", 64'(bus.res_valid), 64'd0);
        chk("add_ack_ready", 64'(bus.start_ready), 64'd1);
        bus.res_ready = 1'b0;

        // 2: mul, inputs stable through EXEC
        issue(OP_MUL, 32'hFFFF_FFFF, 32'd3);
        n = 0;
        while (!bus.res_valid && n < 40) begin
            chk("mul_stable", {bus.alu_ctrl, bus.alu_a, bus.alu_b[27:0]},
                {4'b1000, 32'hFFFF_FFFF, 28'd3});
            @(posedge clock);
            #1;
            n++;
        end
        chk("mul_lat", 64'(n), 64'd4);
        chk("mul_z", {bus.z_hi, bus.z_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("mul_flags", {62'd0, bus.div_by_zero, bus.illegal_op}, 64'd0);
        ack();

        // 3: div by zero bypass, then a real div
        issue(OP_DIV, 32'd100, 32'd0);
        wait_valid(n);
        chk("dz_lat", 64'(n), 64'd1);
        chk("dz_flag", 64'(bus.div_by_zero), 64'd1);
        chk("dz_illegal", 64'(bus.illegal_op), 64'd0);
        chk("dz_z", {bus.z_hi, bus.z_lo}, 64'd0);
        ack();
        chk("dz_clr", 64'(bus.div_by_zero), 64'd0);
        issue(OP_DIV, 32'd100, 32'd7);
        wait_valid(n);
        chk("div_lat", 64'(n), 64'd8);
        chk("div_z", {bus.z_hi, bus.z_lo}, {32'd2, 32'd14});
        chk("div_flag", 64'(bus.div_by_zero), 64'd0);
        ack();

        // 4: illegal op, result held while consumer stalls
        issue(4'b1101, 32'd1, 32'd2);
        wait_valid(n);
        chk("ill_lat", 64'(n), 64'd1);
        chk("ill_flag", 64'(bus.illegal_op), 64'd1);
        chk("ill_z", {bus.z_hi, bus.z_lo}, 64'd0);
        bus.start_valid = 1'b1;
        bus.op          = OP_ADD;
        bus.a_in        = 32'd5;
        bus.b_in        = 32'd7;
        repeat (5) begin
            @(posedge clock);
            #1;
            chk("hold_state", {59'd0, bus.res_valid, bus.start_ready,
                bus.illegal_op, bus.div_by_zero, bus.busy}, 64'b10101);
            chk("hold_out", {bus.alu_ctrl, bus.z_lo, bus.z_hi[27:0]},
                {4'b1101, 60'd0});
        end
        bus.start_valid = 1'b0;
        ack();
        chk("ill_clr", {62'd0, bus.illegal_op, bus.res_valid}, 64'd0);
        chk("ill_idle", 64'(bus.start_ready), 64'd1);

        // 5: async reset in the middle of a div
        issue(OP_DIV, 32'd100, 32'd7);
        @(posedge clock);
        #1;
        chk("mid_busy", 64'(bus.busy), 64'd1);
        #2;
        clear = 1'b0;
        #1;
        chk("ar_ops", {28'd0, bus.alu_ctrl, bus.alu_a}, 64'd0);
        chk("ar_b", {32'd0, bus.alu_b}, 64'd0);
        chk("ar_state", {61'd0, bus.busy, bus.start_ready, bus.res_valid}, 64'b010);
        chk("ar_z", {bus.z_hi, bus.z_lo}, 64'd0);
        @(negedge clock);
        clear = 1'b1;
        @(posedge clock);
        #1;
        chk("ar_ready", 64'(bus.start_ready), 64'd1);
        issue(OP_AND, 32'hF0, 32'h3C);
        wait_valid(n);
        chk("and_lat", 64'(n), 64'd1);
        chk("and_z", {bus.z_hi, bus.z_lo}, 64'h30);
        ack();

        // 6: back-to-back ror then rol with res_ready tied high
        bus.res_ready = 1'b1;
        issue(OP_ROR, 32'h1, 32'd1);
        wait_valid(n);
        chk("ror_lat", 64'(n), 64'd1);
        chk("ror_z", {bus.z_hi, bus.z_lo}, 64'h8000_0000);
        bus.start_valid = 1'b1;
        bus.op          = OP_ROL;
        bus.a_in        = 32'h8000_0000;
        bus.b_in        = 32'd1;
        @(posedge clock);
        #1;
        chk("b2b_idle", {61'd0, bus.start_ready, bus.res_valid, bus.busy}, 64'b100);
        @(posedge clock);
        #1;
        bus.start_valid = 1'b0;
        chk("b2b_accept", {62'd0, bus.busy, bus.start_ready}, 64'b10);
        @(posedge clock);
        #1;
        chk("rol_valid", 64'(bus.res_valid), 64'd1);
        chk("rol_z", {bus.z_hi, bus.z_lo}, 64'h1);
        @(posedge clock);
        #1;
        chk("rol_done", {62'd0, bus.res_valid, bus.start_ready}, 64'b01);
        bus.res_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
